// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Booth recoding of {Q[0], q-1}; the other two codes leave the accumulator alone.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Counter must be able to hold ITERS itself.
  function automatic int unsigned cnt_w(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (trial[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit with HI/LO result registers.
// Optional build macro MULTDIV_ZERO_SHORTCUT_EN: MULT with a zero operand finishes in one cycle.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_w(ITERS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;      // Booth A (WIDTH+1) or division remainder (low WIDTH bits)
  logic [WIDTH-1:0] qr_q, qr_d;        // Booth Q or dividend/quotient shift register
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   mcand_q, mcand_d;  // sign-extended multiplicand or zero-extended |divisor|
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             last_iter;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign last_iter = (cnt_q == CW'(ITERS - 1));
  assign abs_a     = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b     = op_b[WIDTH-1] ? -op_b : op_b;

  always_comb begin
    case ({qr_q[0], qm1_q})
      BOOTH_ADD: booth_sum = acc_q + mcand_q;
      BOOTH_SUB: booth_sum = acc_q - mcand_q;
      default:   booth_sum = acc_q;
    endcase
    {booth_acc, booth_q, booth_qm1} = {booth_sum[WIDTH], booth_sum, qr_q};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .quo_i (qr_q),
    .dvs_i (mcand_q[WIDTH-1:0]),
    .rem_o (rem_next),
    .quo_o (quo_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mult_start) begin
`ifdef MULTDIV_ZERO_SHORTCUT_EN
          if (op_a == '0 || op_b == '0) begin
            state_d = ST_DONE;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
`else
          begin
`endif
            state_d = ST_MULT;
            cnt_d   = '0;
            acc_d   = '0;
            qr_d    = op_b;
            qm1_d   = 1'b0;
            mcand_d = {op_a[WIDTH-1], op_a};
          end
        end else if (div_start) begin
          if (op_b == '0) begin
            state_d = ST_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d   = ST_DIV;
            cnt_d     = '0;
            acc_d     = '0;
            qr_d      = abs_a;
            mcand_d   = {1'b0, abs_b};
            neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem_d = op_a[WIDTH-1];
          end
        end
      end

      ST_MULT: begin
        acc_d = booth_acc;
        qr_d  = booth_q;
        qm1_d = booth_qm1;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = ST_DONE;
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_q;
        end
      end

      ST_DIV: begin
        acc_d = {1'b0, rem_next};
        qr_d  = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = ST_DONE;
          lo_d    = neg_quo_q ? -quo_next : quo_next;
          hi_d    = neg_rem_q ? -rem_next : rem_next;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      qr_q      <= qr_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
  assign done     = (state_q == ST_DONE);
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed literal checks.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .op_a       (op_a),
    .op_b       (op_b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of the current operation in terms of clock edges.
  longint      edge_n  = 0;
  longint      a_edge  = -100;
  longint      d_edge  = -10;
  bit          long_op = 1'b0;
  logic [31:0] cur_hi  = '0;
  logic [31:0] cur_lo  = '0;
  logic [31:0] pend_hi = '0;
  logic [31:0] pend_lo = '0;
  bit          pend_dz = 1'b0;
  longint      m_prod, m_sa, m_sb;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cur_hi  = '0;
      cur_lo  = '0;
      long_op = 1'b0;
      pend_dz = 1'b0;
      d_edge  = edge_n - 10;
    end else begin
      edge_n++;
      if (edge_n >= d_edge + 2 && (mult_start || div_start)) begin
        if (mult_start) begin
          m_prod = longint'($signed(op_a)) * longint'($signed(op_b));
          {pend_hi, pend_lo} = m_prod;
          pend_dz = 1'b0;
          long_op = 1'b1;
`ifdef MULTDIV_ZERO_SHORTCUT_EN
          if (op_a == 0 || op_b == 0) long_op = 1'b0;
`endif
        end else if (op_b == 0) begin
          pend_hi = cur_hi;
          pend_lo = cur_lo;
          pend_dz = 1'b1;
          long_op = 1'b0;
        end else begin
          m_sa    = longint'($signed(op_a));
          m_sb    = longint'($signed(op_b));
          pend_lo = 32'(m_sa / m_sb);
          pend_hi = 32'(m_sa % m_sb);
          pend_dz = 1'b0;
          long_op = 1'b1;
        end
        a_edge = edge_n;
        d_edge = long_op ? edge_n + 32 : edge_n;
      end
      if (edge_n == d_edge) begin
        cur_hi = pend_hi;
        cur_lo = pend_lo;
      end
    end
  end

  // Compare process: every cycle outside reset, DUT outputs against the model.
  bit e_busy, e_done;
  int txn = 0;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      e_busy = long_op && (edge_n >= a_edge) && (edge_n <= a_edge + 31);
      e_done = (edge_n == d_edge);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("div_zero", 32'(div_zero), 32'(e_done && pend_dz));
      chk("hi", hi, cur_hi);
      chk("lo", lo, cur_lo);
      if (done) begin
        txn++;
        $display("txn %0d: hi=%08h lo=%08h div_zero=%0b", txn, hi, lo, div_zero);
      end
    end
  end

  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult_start = m;
    div_start  = d;
    op_a       = a;
    op_b       = b;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
  endtask

  // Returns the cycle index (start edge = cycle 0) in which done was seen and busy-cycle count.
  task automatic wait_done(input bit noise, output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy) nbusy++;
      if (noise) begin
        mult_start = ($urandom_range(5) == 0);
        div_start  = ($urandom_range(5) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    mult_start = 1'b0;
    div_start  = 1'b0;
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  int c, nb, nd, first_done, kind;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    #1 reset = 1'b0;

    // 7 * -3
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(1'b0, c, nb);
    chk("mul_lat", 32'(c), 32'd33);
    chk("mul_busy_cycles", 32'(nb), 32'd32);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFEB);

    // -7 / 2
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, c, nb);
    chk("div_lat", 32'(c), 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dz", 32'(div_zero), 32'd0);

    // 5 / 0
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done(1'b0, c, nb);
    chk("dz_lat", 32'(c), 32'd1);
    chk("dz_flag", 32'(div_zero), 32'd1);
    chk("dz_hi_keep", hi, 32'hFFFF_FFFF);
    chk("dz_lo_keep", lo, 32'hFFFF_FFFD);

    // Overflow divide, then multiply of the same operands
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, c, nb);
    chk("ovf_div_lo", lo, 32'h8000_0000);
    chk("ovf_div_hi", hi, 32'h0000_0000);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, c, nb);
    chk("ovf_mul_hi", hi, 32'h0000_0000);
    chk("ovf_mul_lo", lo, 32'h8000_0000);

    // Simultaneous starts: MULT wins; a later div_start is ignored
    issue(1'b1, 1'b1, 32'd6, 32'd4);
    nd = 0;
    first_done = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        nd++;
        if (first_done == 0) first_done = k;
      end
      div_start = (k == 10);
      @(negedge clk);
    end
    div_start = 1'b0;
    chk("both_ndone", 32'(nd), 32'd1);
    chk("both_lat", 32'(first_done), 32'd33);
    chk("both_lo", lo, 32'd24);
    chk("both_hi", hi, 32'd0);

    // Most negative squared
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(1'b0, c, nb);
    chk("minsq_hi", hi, 32'h4000_0000);
    chk("minsq_lo", lo, 32'h0000_0000);

    // Reset in the middle of a multiply
    issue(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    issue(1'b1, 1'b0, 32'd3, 32'd3);
    wait_done(1'b0, c, nb);
    chk("after_rst_lat", 32'(c), 32'd33);
    chk("after_rst_lo", lo, 32'd9);
    chk("after_rst_hi", hi, 32'd0);

    // Randomized operations against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(4);
      issue(kind < 2 || kind == 4, kind >= 2, pick_operand(), pick_operand());
      wait_done(1'($urandom_range(1)), c, nb);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the 32-bit CPU datapath.
- Executes MULT (radix-2 Booth) and DIV (restoring, signed) one iteration per clock.
- Holds results in internal HI/LO registers. These feed the HI and LO inputs of the write-back data selector in front of the register file.
- The control unit starts an operation and waits for `done`.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITERS, WIDTH, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mult_start  input  1  request signed multiply of op_a*op_b; sampled only in IDLE
- div_start  input  1  request signed divide op_a/op_b; sampled only in IDLE
- op_a  input  WIDTH  multiplicand / dividend (two's complement)
- op_b  input  WIDTH  multiplier / divisor (two's complement)
- hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
- lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient
- busy  output  1  high in MULT and DIV states
- done  output  1  one-cycle pulse, high in DONE state
- div_zero  output  1  high with done when a DIV had op_b==0; otherwise low

Behaviour:
- Reset: one clock, asynchronous, active-high.
  - All registers clear immediately: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
  - Reset mid-operation abandons the operation; hi/lo read 0 afterwards.
- FSM states: IDLE, MULT, DIV, DONE.
- IDLE:
  - mult_start=1 → MULT. Latch op_a/op_b, clear counter and accumulator.
  - div_start=1 and op_b!=0 → DIV. Latch operands, record signs, take absolute values.
  - div_start=1 and op_b==0 → DONE directly with div_zero=1; hi/lo unchanged.
  - mult_start and div_start both high → MULT wins; div request dropped.
- Start requests in any state other than IDLE are ignored; operands are not re-sampled.
- MULT:
  - Booth step per cycle on {A(W+1), Q(W), q-1}: add/subtract multiplicand per {Q[0], q-1}, then arithmetic shift right.
  - Counter increments each cycle. After ITERS cycles → DONE; hi/lo load the 2W-bit product on that edge.
- DIV:
  - Restoring step per cycle on unsigned magnitudes: shift {R,Q} left, trial-subtract |divisor|, restore on negative.
  - After ITERS cycles → DONE.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder is negated if the dividend is negative (remainder takes the sign of the dividend).
  - Overflow case: op_a = most negative value (0x80000000 for WIDTH=32), op_b = -1 → lo=0x80000000, hi=0 (wraps, no flag).
- DONE: done=1 for exactly one cycle, then → IDLE.
  - div_zero is valid only while done=1.
  - A new start may be accepted on the cycle after DONE, i.e. in IDLE.
- Latency, measured from the start-sampling edge (cycle 0):
  - normal op: busy high cycles 1..32, done high in cycle 33.
  - divide by zero: done high in cycle 1.
- hi/lo hold their values between operations. They change only on entry to DONE or on reset.
- The most negative operand is legal for MULT: 0x80000000*0x80000000 = 0x4000000000000000.

Optional Feature:
- Macro: MULTDIV_ZERO_SHORTCUT_EN.
- Defined: in IDLE, MULT with op_a==0 or op_b==0 goes directly to DONE; hi=lo=0; done high in cycle 1.
- Not defined: zero operands take the full 32 cycles, with identical results.

Decomposition:
- Package mult_div_pkg:
  - state enum (IDLE, MULT, DIV, DONE);
  - localparam for counter width, $clog2(ITERS+1);
  - Booth encoding constants for {Q[0], q-1}.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once; the FSM/register file stays in mult_div_unit.

Test Plan:
- op_a=7, op_b=-3, mult_start pulse → done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-32.
- op_a=-7, op_b=2, div_start pulse → done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- op_a=5, op_b=0, div_start → done and div_zero high in cycle 1, hi/lo keep the previous result.
- op_a=0x80000000, op_b=0xFFFFFFFF, div_start → lo=0x80000000, hi=0; then mult of the same operands → hi=0x00000000, lo=0x80000000.
- mult_start and div_start together with op_a=6, op_b=4 → MULT executes, lo=24; a div_start pulsed at cycle 10 is ignored; exactly one done.
- Start MULT, assert reset at cycle 15 → outputs zero immediately, state IDLE; a new mult 3*3 then gives lo=9 at cycle 33.
